bus_arbiter_mux: RTL and testbench

- Registered, arbitrated successor to the Basic Computer common-bus multiplexer.
- NSRC sources each raise a request; the block arbitrates in fixed-priority or round-robin mode and registers the winner's word onto BUS.
- Supports bounded multi-cycle bus ownership (LOCK), enforced by a hold-timeout counter.
- Sits between register/memory sources and all bus loaders; replaces the external SEL encoder.

---
 rtl/bus_pkg.sv | 13 +
 rtl/rr_priority_pick.sv | 39 +++
 rtl/bus_arbiter_mux.sv | 127 ++++++++++++
 tb/tb_bus_arbiter_mux.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the arbitrated bus multiplexer.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational picker: fixed priority (lowest index) or round robin from ptr.
module rr_priority_pick
    import bus_pkg::*;
#(
    parameter  int unsigned NSRC = 8,
    localparam int unsigned SELW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    output logic [NSRC-1:0] pick,
    output logic [SELW-1:0] idx,
    output logic            any
);

    // Scan candidates starting at 0 (fixed) or ptr (round robin), wrapping once.
    always_comb begin
        int unsigned cand;
        logic [SELW-1:0] cand_idx;
        pick     = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            cand = (mode == MODE_RR) ? 32'(ptr) + k : k;
            if (cand >= NSRC) begin
                cand = cand - NSRC;
            end
            cand_idx = SELW'(cand);
            if (!any && req[cand_idx]) begin
                any            = 1'b1;
                idx            = cand_idx;
                pick[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered, arbitrated bus multiplexer with bounded lock and forced release.
module bus_arbiter_mux
    import bus_pkg::*;
#(
    parameter  int unsigned WIDTH    = 16,
    parameter  int unsigned NSRC     = 8,
    parameter  int unsigned MAX_HOLD = 4,
    localparam int unsigned SELW     = $clog2(NSRC),
    localparam int unsigned CNTW     = $clog2(MAX_HOLD + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*WIDTH-1:0] data,
    input  logic [NSRC-1:0]       req,
    input  logic                  lock,
    input  logic                  mode,
    output logic [WIDTH-1:0]      bus,
    output logic                  bus_valid,
    output logic [NSRC-1:0]       gnt,
    output logic [SELW-1:0]       gnt_id,
    output logic                  timeout
);

    state_t            state, state_nx;
    logic [SELW-1:0]   rr_ptr, rr_nx, gnt_id_nx;
    logic [CNTW-1:0]   hold_cnt, hold_nx;
    logic [NSRC-1:0]   gnt_nx, mask_c, pick_gnt;
    logic [SELW-1:0]   pick_idx, rr_after_c;
    logic [WIDTH-1:0]  bus_nx, owner_data_c, win_data_c;
    logic              valid_nx, timeout_nx, pick_any, arb;
    logic              keep_c, forced_c;

    // Owner wants to hold the bus; forced release once the hold budget is spent.
    assign keep_c       = lock && req[gnt_id];
    assign forced_c     = (state == LOCKED) && keep_c && (hold_cnt == CNTW'(MAX_HOLD));
    assign mask_c       = forced_c ? ({{(NSRC-1){1'b0}}, 1'b1} << gnt_id) : '0;
    assign owner_data_c = data[32'(gnt_id) * WIDTH +: WIDTH];
    assign win_data_c   = data[32'(pick_idx) * WIDTH +: WIDTH];
    assign rr_after_c   = (pick_idx == SELW'(NSRC - 1)) ? '0 : pick_idx + SELW'(1);

    rr_priority_pick #(.NSRC(NSRC)) u_pick (
        .req  (req & ~mask_c),
        .ptr  (rr_ptr),
        .mode (mode),
        .pick (pick_gnt),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Next-state, hold counter and output register next values.
    always_comb begin
        state_nx   = state;
        rr_nx      = rr_ptr;
        hold_nx    = hold_cnt;
        gnt_nx     = gnt;
        gnt_id_nx  = gnt_id;
        bus_nx     = bus;
        valid_nx   = bus_valid;
        timeout_nx = 1'b0;
        arb        = 1'b0;
        case (state)
            IDLE: arb = 1'b1;
            GRANT: begin
                if (keep_c) begin
                    state_nx = LOCKED;
                    hold_nx  = CNTW'(1);
                    bus_nx   = owner_data_c;
                end else begin
                    arb = 1'b1;
                end
            end
            LOCKED: begin
                if (keep_c && (hold_cnt < CNTW'(MAX_HOLD))) begin
                    hold_nx = hold_cnt + CNTW'(1);
                    bus_nx  = owner_data_c;
                end else begin
                    arb        = 1'b1;
                    timeout_nx = forced_c;
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                valid_nx = 1'b0;
            end
        endcase
        if (arb) begin
            hold_nx = '0;
            if (pick_any) begin
                state_nx  = GRANT;
                gnt_nx    = pick_gnt;
                gnt_id_nx = pick_idx;
                bus_nx    = win_data_c;
                valid_nx  = 1'b1;
                rr_nx     = rr_after_c;
            end else begin
                state_nx = IDLE;
                gnt_nx   = '0;
                valid_nx = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            bus       <= '0;
            bus_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            hold_cnt  <= hold_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            bus       <= bus_nx;
            bus_valid <= valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench for bus_arbiter_mux (WIDTH=16, NSRC=8, MAX_HOLD=4).
module tb_bus_arbiter_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] data;
    logic [7:0]   req;
    logic         lock;
    logic         mode;
    logic [15:0]  bus;
    logic         bus_valid;
    logic [7:0]   gnt;
    logic [2:0]   gnt_id;
    logic         timeout;

    logic [15:0]  word [8];
    int           vectors = 0;
    int           miscompares = 0;

    bus_arbiter_mux #(.WIDTH(16), .NSRC(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .req       (req),
        .lock      (lock),
        .mode      (mode),
        .bus       (bus),
        .bus_valid (bus_valid),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) data[i*16 +: 16] = word[i];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) word[i] = 16'(16'hA5A0 + i * 16'h0101);
        req  = 8'h00;
        lock = 1'b0;
        mode = 1'b0;

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk("rst_bus", 32'(bus), 0);
        chk("rst_valid", 32'(bus_valid), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_id", 32'(gnt_id), 0);
        chk("rst_to", 32'(timeout), 0);
        step();
        step();
        rst = 1'b0;

        // Round robin over all sources from rr_ptr=0
        mode = 1'b1;
        req  = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rr_id", 32'(gnt_id), 32'(k % 8));
            chk("rr_gnt", 32'(gnt), 32'(8'h01 << (k % 8)));
            chk("rr_bus", 32'(bus), 32'(word[k % 8]));
        end
        req = 8'h00;
        step();
        chk("rr_idle_valid", 32'(bus_valid), 0);
        chk("rr_idle_gnt", 32'(gnt), 0);
        chk("rr_idle_id", 32'(gnt_id), 1);
        chk("rr_idle_bus", 32'(bus), 32'(word[1]));

        // Fixed priority: sources 2,5,7 request, 2 wins; bus follows DATA2
        mode = 1'b0;
        req  = 8'b1010_0100;
        step();
        chk("fp_id0", 32'(gnt_id), 2);
        chk("fp_gnt0", 32'(gnt), 32'h04);
        chk("fp_bus0", 32'(bus), 32'(word[2]));
        word[2] = 16'h2222;
        step();
        chk("fp_id1", 32'(gnt_id), 2);
        chk("fp_bus1", 32'(bus), 32'h2222);
        word[2] = 16'h2BBB;
        step();
        chk("fp_id2", 32'(gnt_id), 2);
        chk("fp_bus2", 32'(bus), 32'h2BBB);
        req = 8'h00;
        step();
        chk("fp_idle", 32'(bus_valid), 0);

        // Lock with competitor: 1 GRANT + 4 LOCKED on 3, then forced to 5
        req  = 8'h28;
        lock = 1'b1;
        step();
        chk("lk_grant_id", 32'(gnt_id), 3);
        chk("lk_grant_bus", 32'(bus), 32'(word[3]));
        chk("lk_grant_to", 32'(timeout), 0);
        for (int k = 0; k < 4; k++) begin
            word[3] = 16'(16'h3000 + k);
            step();
            chk("lk_hold_id", 32'(gnt_id), 3);
            chk("lk_hold_bus", 32'(bus), 32'(16'h3000 + k));
            chk("lk_hold_to", 32'(timeout), 0);
        end
        step();
        chk("lk_rel_id", 32'(gnt_id), 5);
        chk("lk_rel_gnt", 32'(gnt), 32'h20);
        chk("lk_rel_to", 32'(timeout), 1);
        chk("lk_rel_bus", 32'(bus), 32'(word[5]));
        lock = 1'b0;
        step();
        chk("lk_after_id", 32'(gnt_id), 3);
        chk("lk_after_to", 32'(timeout), 0);
        req = 8'h00;
        step();
        chk("lk_idle", 32'(bus_valid), 0);

        // Timeout with no other requester: IDLE one cycle, then 3 again
        req  = 8'h08;
        lock = 1'b1;
        step();
        chk("solo_grant", 32'(gnt_id), 3);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("solo_hold", 32'(gnt), 32'h08);
        end
        step();
        chk("solo_rel_valid", 32'(bus_valid), 0);
        chk("solo_rel_gnt", 32'(gnt), 0);
        chk("solo_rel_to", 32'(timeout), 1);
        step();
        chk("solo_regrant_valid", 32'(bus_valid), 1);
        chk("solo_regrant_id", 32'(gnt_id), 3);
        chk("solo_regrant_to", 32'(timeout), 0);
        lock = 1'b0;
        req  = 8'h00;
        step();
        chk("solo_idle", 32'(bus_valid), 0);

        // Early unlock in round robin (rr_ptr=4), then mode switch
        mode = 1'b1;
        req  = 8'h30;
        lock = 1'b1;
        step();
        chk("eu_grant", 32'(gnt_id), 4);
        step();
        step();
        chk("eu_lock2_id", 32'(gnt_id), 4);
        lock = 1'b0;
        step();
        chk("eu_rearb_id", 32'(gnt_id), 5);
        chk("eu_rearb_to", 32'(timeout), 0);
        step();
        chk("eu_rr_wrap", 32'(gnt_id), 4);
        mode = 1'b0;
        step();
        chk("ms_fixed", 32'(gnt_id), 4);
        mode = 1'b1;
        step();
        chk("ms_rr_back", 32'(gnt_id), 5);
        req = 8'h00;
        step();

        // Reset mid-lock (hold_cnt=2), asynchronous
        mode = 1'b0;
        req  = 8'h40;
        lock = 1'b1;
        step();
        step();
        step();
        chk("ml_pre_id", 32'(gnt_id), 6);
        chk("ml_pre_valid", 32'(bus_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("ml_bus", 32'(bus), 0);
        chk("ml_valid", 32'(bus_valid), 0);
        chk("ml_gnt", 32'(gnt), 0);
        chk("ml_id", 32'(gnt_id), 0);
        chk("ml_to", 32'(timeout), 0);
        #1 rst = 1'b0;
        req  = 8'h01;
        lock = 1'b0;
        step();
        chk("ml_post_gnt", 32'(gnt), 32'h01);
        chk("ml_post_bus", 32'(bus), 32'(word[0]));
        chk("ml_post_valid", 32'(bus_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
